// File: rtl/seg7_scan_driver.sv
// Four-digit common-anode seven-segment scan driver with a load-strobed snapshot,
// inter-digit blanking gap, optional leading-zero blanking and a fixed decimal point.
module seg7_scan_driver #(
    parameter int SCAN_DIV   = 100000,
    parameter int GAP_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [3:0] seconds,
    input  logic [3:0] tenths,
    input  logic [3:0] hundredths,
    input  logic [3:0] thousandths,
    input  logic       blank_lz,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an,
    output logic       frame_done
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(SCAN_DIV - 1);
    localparam logic [GW-1:0] G_LAST = GW'(GAP_CYCLES - 1);

    localparam logic [1:0] ST_PEND = 2'd0;
    localparam logic [1:0] ST_SHOW = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    logic [1:0]    state, state_n;
    logic [1:0]    idx, idx_n;
    logic [PW-1:0] pcnt, pcnt_n;
    logic [GW-1:0] gcnt, gcnt_n;
    logic          slot_start;
    logic [3:0]    snap_s, snap_t, snap_h, snap_th;
    logic [3:0]    digit_sel;
    logic [6:0]    seg_dec;

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'b1000000;
            4'd1:    decode = 7'b1111001;
            4'd2:    decode = 7'b0100100;
            4'd3:    decode = 7'b0110000;
            4'd4:    decode = 7'b0011001;
            4'd5:    decode = 7'b0010010;
            4'd6:    decode = 7'b0000010;
            4'd7:    decode = 7'b1111000;
            4'd8:    decode = 7'b0000000;
            4'd9:    decode = 7'b0010000;
            default: decode = 7'b0111111;
        endcase
    endfunction

    // Next-state logic; slot_start marks the edge where a new digit is decoded.
    always_comb begin
        state_n    = state;
        idx_n      = idx;
        pcnt_n     = pcnt;
        gcnt_n     = gcnt;
        slot_start = 1'b0;
        case (state)
            ST_PEND: begin
                state_n    = ST_SHOW;
                idx_n      = 2'd0;
                pcnt_n     = '0;
                slot_start = 1'b1;
            end
            ST_SHOW: begin
                if (pcnt == P_LAST) begin
                    pcnt_n = '0;
                    if (GAP_CYCLES > 0) begin
                        state_n = ST_GAP;
                        gcnt_n  = '0;
                    end else begin
                        idx_n      = idx + 2'd1;
                        slot_start = 1'b1;
                    end
                end else begin
                    pcnt_n = pcnt + 1'b1;
                end
            end
            ST_GAP: begin
                if (gcnt == G_LAST) begin
                    state_n    = ST_SHOW;
                    idx_n      = idx + 2'd1;
                    pcnt_n     = '0;
                    gcnt_n     = '0;
                    slot_start = 1'b1;
                end else begin
                    gcnt_n = gcnt + 1'b1;
                end
            end
            default: state_n = ST_PEND;
        endcase
    end

    always_comb begin
        case (idx_n)
            2'd0:    digit_sel = snap_th;
            2'd1:    digit_sel = snap_h;
            2'd2:    digit_sel = snap_t;
            default: digit_sel = snap_s;
        endcase
        seg_dec = decode(digit_sel);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_PEND;
            idx        <= 2'd0;
            pcnt       <= '0;
            gcnt       <= '0;
            snap_s     <= 4'd0;
            snap_t     <= 4'd0;
            snap_h     <= 4'd0;
            snap_th    <= 4'd0;
            seg        <= 7'h7F;
            dp         <= 1'b1;
            an         <= 4'hF;
            frame_done <= 1'b0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
            pcnt  <= pcnt_n;
            gcnt  <= gcnt_n;
            if (load) begin
                snap_s  <= seconds;
                snap_t  <= tenths;
                snap_h  <= hundredths;
                snap_th <= thousandths;
            end
            // Slot start decodes the pre-edge snapshot, so a load never alters a lit digit.
            if (slot_start) begin
                an  <= ~(4'b0001 << idx_n);
                dp  <= (idx_n != 2'd3);
                seg <= (idx_n == 2'd3 && blank_lz && snap_s == 4'd0) ? 7'h7F : seg_dec;
            end else if (state_n == ST_GAP) begin
                an  <= 4'hF;
                dp  <= 1'b1;
                seg <= 7'h7F;
            end
            frame_done <= (state_n == ST_SHOW) && (idx_n == 2'd3) && (pcnt_n == P_LAST);
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: a SCAN_DIV=4/GAP=2 instance checked frame by frame,
// plus a SCAN_DIV=1/GAP=0 instance for the gapless rotation.
module tb_seg7_scan_driver;

    logic       clk = 1'b0;
    logic       rst_n, load, blank_lz;
    logic [3:0] seconds, tenths, hundredths, thousandths;
    logic [6:0] seg, f_seg;
    logic       dp, f_dp, frame_done, f_fd;
    logic [3:0] an, f_an;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [3:0] s, t, h, th;
        logic       blz;
        logic [6:0] e0, e1, e2, e3;
    } vec_t;
    vec_t vecs [6];

    always #5 clk = ~clk;

    seg7_scan_driver #(.SCAN_DIV(4), .GAP_CYCLES(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .load(load), .seconds(seconds), .tenths(tenths),
        .hundredths(hundredths), .thousandths(thousandths), .blank_lz(blank_lz),
        .seg(seg), .dp(dp), .an(an), .frame_done(frame_done)
    );

    seg7_scan_driver #(.SCAN_DIV(1), .GAP_CYCLES(0)) u_fast (
        .clk(clk), .rst_n(rst_n), .load(load), .seconds(seconds), .tenths(tenths),
        .hundredths(hundredths), .thousandths(thousandths), .blank_lz(blank_lz),
        .seg(f_seg), .dp(f_dp), .an(f_an), .frame_done(f_fd)
    );

    // Packed as {an, seg, dp, frame_done}
    task automatic chk(input string name, input logic [12:0] act, input logic [12:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got an/seg/dp/fd=%h expected %h", name, act, exp);
        end
    endtask

    // Call at the negedge showing the first cycle of an[0]; returns at the next frame start.
    task automatic check_frame(input string name, input logic [6:0] e0, e1, e2, e3,
                               input int load_at, input logic [3:0] load_h);
        logic [6:0]  es [4];
        logic [12:0] exp;
        int          slot, w;
        es[0] = e0; es[1] = e1; es[2] = e2; es[3] = e3;
        for (int k = 0; k < 24; k++) begin
            slot = k / 6;
            w    = k % 6;
            if (w < 4)
                exp = {~(4'b0001 << slot), es[slot], (slot == 3) ? 1'b0 : 1'b1,
                       (slot == 3 && w == 3) ? 1'b1 : 1'b0};
            else
                exp = {4'hF, 7'h7F, 1'b1, 1'b0};
            chk($sformatf("%s k=%0d", name, k), {an, seg, dp, frame_done}, exp);
            if (k == load_at) begin
                load = 1'b1;
                hundredths = load_h;
            end else begin
                load = 1'b0;
            end
            @(negedge clk);
        end
        load = 1'b0;
    endtask

    task automatic wait_fd();
        int i = 0;
        while (!frame_done && i < 40) begin
            @(negedge clk);
            i++;
        end
        chk("wait frame_done", {12'd0, frame_done}, 13'd1);
    endtask

    initial begin
        rst_n = 1'b0; load = 1'b0; blank_lz = 1'b0;
        seconds = 4'd0; tenths = 4'd0; hundredths = 4'd0; thousandths = 4'd0;
        vecs[0] = '{4'd1, 4'd2, 4'd3, 4'd4,  1'b0, 7'h19, 7'h30, 7'h24, 7'h79};
        vecs[1] = '{4'd0, 4'd5, 4'd6, 4'd7,  1'b1, 7'h78, 7'h02, 7'h12, 7'h7F};
        vecs[2] = '{4'd0, 4'd5, 4'd6, 4'd7,  1'b0, 7'h78, 7'h02, 7'h12, 7'h40};
        vecs[3] = '{4'd9, 4'hC, 4'd8, 4'd0,  1'b0, 7'h40, 7'h00, 7'h3F, 7'h10};
        vecs[4] = '{4'd8, 4'd9, 4'hF, 4'hA,  1'b1, 7'h3F, 7'h3F, 7'h10, 7'h00};
        vecs[5] = '{4'd0, 4'd0, 4'd0, 4'd0,  1'b1, 7'h40, 7'h40, 7'h40, 7'h7F};

        #12;
        chk("reset main", {an, seg, dp, frame_done}, {4'hF, 7'h7F, 1'b1, 1'b0});
        chk("reset fast", {f_an, f_seg, f_dp, f_fd}, {4'hF, 7'h7F, 1'b1, 1'b0});
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        check_frame("idle0", 7'h40, 7'h40, 7'h40, 7'h40, -1, 4'd0);
        check_frame("idle1", 7'h40, 7'h40, 7'h40, 7'h40, -1, 4'd0);

        // Load during the gap after frame_done so the next frame shows the new snapshot.
        for (int i = 0; i < 6; i++) begin
            wait_fd();
            seconds = vecs[i].s; tenths = vecs[i].t;
            hundredths = vecs[i].h; thousandths = vecs[i].th;
            blank_lz = vecs[i].blz;
            load = 1'b1;
            @(negedge clk);
            load = 1'b0;
            @(negedge clk);
            @(negedge clk);
            check_frame($sformatf("vec%0d", i), vecs[i].e0, vecs[i].e1, vecs[i].e2, vecs[i].e3,
                        -1, 4'd0);
        end

        // Load on the 2nd cycle of the an[1] slot: current slot keeps old value.
        check_frame("midload", 7'h40, 7'h40, 7'h40, 7'h7F, 7, 4'd7);
        check_frame("midload_next", 7'h40, 7'h78, 7'h40, 7'h7F, -1, 4'd0);

        // Asynchronous reset in the middle of the idx2 slot.
        repeat (13) @(negedge clk);
        chk("pre-reset idx2", {an, 9'd0}, {4'b1011, 9'd0});
        #2;
        rst_n = 1'b0;
        #1;
        chk("async reset main", {an, seg, dp, frame_done}, {4'hF, 7'h7F, 1'b1, 1'b0});
        chk("async reset fast", {f_an, f_seg, f_dp, f_fd}, {4'hF, 7'h7F, 1'b1, 1'b0});
        blank_lz = 1'b0;
        hundredths = 4'd0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_frame("after_reset", 7'h40, 7'h40, 7'h40, 7'h40, -1, 4'd0);

        // Gapless instance: rotate every cycle, frame_done with an[3].
        begin
            int i = 0;
            while (!f_fd && i < 10) begin
                @(negedge clk);
                i++;
            end
            chk("fast wait frame_done", {12'd0, f_fd}, 13'd1);
        end
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            chk($sformatf("fast j=%0d", j), {f_an, f_seg, f_dp, f_fd},
                {~(4'b0001 << (j % 4)), 7'h40, (j % 4 == 3) ? 1'b0 : 1'b1,
                 (j % 4 == 3) ? 1'b1 : 1'b0});
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
